freq_meter_mc: RTL



---
 rtl/freq_meter_mc.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/freq_meter_mc.sv
// Multi-channel gated rising-edge frequency meter with one-shot/continuous modes and a registered result bank.
// Optional macro FREQMEAS_HZ_EN scales each latched count by HZ_MULT, saturating to all-ones with ovf set.
module freq_meter_mc #(
  parameter int NCH         = 4,
  parameter int CW          = 32,
  parameter int GATE_CYCLES = 100000,
  parameter int SYNC_STAGES = 2,
  parameter int HZ_MULT     = 2000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              oneshot,
  input  logic              start,
  input  logic [NCH-1:0]    sig_in,
  output logic              busy,
  output logic              done,
  output logic [NCH*CW-1:0] cnt_out,
  output logic [NCH-1:0]    ovf
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_GATE, S_LATCH} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_mode_cont;
  logic [GW-1:0]          r_gcnt;
  logic [SYNC_STAGES-1:0] r_sync [NCH];
  logic [NCH-1:0]         r_hist;
  logic [NCH-1:0]         w_edge;
  logic [CW-1:0]          r_cnt [NCH];
  logic [NCH-1:0]         r_ovf_int;
  logic                   w_gate_entry;
  logic                   w_latch;
  logic [NCH*CW-1:0]      w_res;
  logic [NCH-1:0]         w_res_ovf;

  always_comb begin
    w_state_nxt  = r_state;
    w_gate_entry = 1'b0;
    w_latch      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en && (!oneshot || start)) begin
          w_state_nxt  = S_GATE;
          w_gate_entry = 1'b1;
        end
      end
      S_GATE: begin
        if (!en) begin
          w_state_nxt = S_IDLE;
        end else if (r_gcnt == GATE_LAST) begin
          w_state_nxt = S_LATCH;
        end
      end
      S_LATCH: begin
        if (!en) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_latch = 1'b1;
          if (r_mode_cont) begin
            w_state_nxt  = S_GATE;
            w_gate_entry = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      r_mode_cont <= 1'b0;
      r_gcnt      <= '0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= (w_state_nxt != S_IDLE);
      done    <= w_latch;
      // Mode is captured only when leaving IDLE so mid-run oneshot changes wait for the next start.
      if (r_state == S_IDLE && w_gate_entry) r_mode_cont <= !oneshot;
      if (w_gate_entry) begin
        r_gcnt <= '0;
      end else if (r_state == S_GATE && r_gcnt != GATE_LAST) begin
        r_gcnt <= r_gcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) r_sync[i] <= '0;
      r_hist <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], sig_in[i]};
        r_hist[i] <= r_sync[i][SYNC_STAGES-1];
      end
    end
  end

  always_comb begin
    w_edge = '0;
    for (int i = 0; i < NCH; i++) w_edge[i] = r_sync[i][SYNC_STAGES-1] & ~r_hist[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
      r_ovf_int <= '0;
    end else if (w_gate_entry) begin
      for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
      r_ovf_int <= '0;
    end else if (r_state == S_GATE) begin
      for (int i = 0; i < NCH; i++) begin
        if (w_edge[i]) begin
          if (&r_cnt[i]) r_ovf_int[i] <= 1'b1;
          else           r_cnt[i]     <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef FREQMEAS_HZ_EN
  localparam int MW = CW + $clog2(HZ_MULT + 1);
  logic [MW-1:0] w_prod [NCH];

  always_comb begin
    w_res     = '0;
    w_res_ovf = '0;
    for (int i = 0; i < NCH; i++) begin
      w_prod[i] = MW'(r_cnt[i]) * MW'(HZ_MULT);
      if (|w_prod[i][MW-1:CW]) begin
        w_res[i*CW +: CW] = '1;
        w_res_ovf[i]      = 1'b1;
      end else begin
        w_res[i*CW +: CW] = w_prod[i][CW-1:0];
        w_res_ovf[i]      = r_ovf_int[i];
      end
    end
  end
`else
  logic w_unused_hz;
  assign w_unused_hz = (HZ_MULT != 0);

  always_comb begin
    w_res = '0;
    for (int i = 0; i < NCH; i++) w_res[i*CW +: CW] = r_cnt[i];
    w_res_ovf = r_ovf_int;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_out <= '0;
      ovf     <= '0;
    end else if (w_latch) begin
      cnt_out <= w_res;
      ovf     <= w_res_ovf;
    end
  end

endmodule
